// File: rtl/key_event_pkg.sv
// Shared types and default timing constants for the key event decoder.
package key_event_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRESSED,
        LONG
    } key_state_t;

    // Defaults assume the 50 MHz system clock: 0.5 s long-press, 0.1 s repeat.
    localparam int unsigned DEFAULT_LONG_CYCLES   = 25_000_000;
    localparam int unsigned DEFAULT_REPEAT_CYCLES = 5_000_000;
    localparam int unsigned DEFAULT_CNT_W         = 25;

endpackage

// File: rtl/key_event_fsm.sv
// Single-key event generator: edge register, hold counter and IDLE/PRESSED/LONG FSM.
module key_event_fsm
    import key_event_pkg::*;
#(
    parameter int unsigned LONG_CYCLES   = DEFAULT_LONG_CYCLES,
    parameter int unsigned REPEAT_CYCLES = DEFAULT_REPEAT_CYCLES,
    parameter int unsigned CNT_W         = DEFAULT_CNT_W
) (
    input  logic clk_50MHz,
    input  logic reset,
    input  logic key_in,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse,
    output logic repeat_pulse,
    output logic key_held
);

    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

    key_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic             key_q;
    logic             rise;
    logic             fall;

    assign rise = key_in & ~key_q;
    assign fall = ~key_in & key_q;

    always_ff @(posedge clk_50MHz) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= '0;
            key_q         <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
            repeat_pulse  <= 1'b0;
            key_held      <= 1'b0;
        end else begin
            key_q         <= key_in;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
            repeat_pulse  <= 1'b0;
            unique case (state)
                IDLE: begin
                    cnt <= '0;
                    if (rise) begin
                        state       <= PRESSED;
                        press_pulse <= 1'b1;
                        key_held    <= 1'b1;
                    end
                end
                PRESSED: begin
                    // A fall on the threshold cycle is reported as a release only.
                    if (fall) begin
                        state         <= IDLE;
                        cnt           <= '0;
                        release_pulse <= 1'b1;
                        key_held      <= 1'b0;
                    end else if (cnt == LONG_LAST) begin
                        state      <= LONG;
                        cnt        <= '0;
                        long_pulse <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                LONG: begin
                    if (fall) begin
                        state         <= IDLE;
                        cnt           <= '0;
                        release_pulse <= 1'b1;
                        key_held      <= 1'b0;
                    end else if (cnt == REPEAT_LAST) begin
                        cnt          <= '0;
                        repeat_pulse <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/key_event_decoder.sv
// Turns debounced key levels into press/release/long/repeat pulses and a held level, one FSM per key.
module key_event_decoder
    import key_event_pkg::*;
#(
    parameter int unsigned N_KEYS        = 4,
    parameter int unsigned LONG_CYCLES   = DEFAULT_LONG_CYCLES,
    parameter int unsigned REPEAT_CYCLES = DEFAULT_REPEAT_CYCLES,
    parameter int unsigned CNT_W         = DEFAULT_CNT_W
) (
    input  logic              clk_50MHz,
    input  logic              reset,
    input  logic [N_KEYS-1:0] key_in,
    output logic [N_KEYS-1:0] press_pulse,
    output logic [N_KEYS-1:0] release_pulse,
    output logic [N_KEYS-1:0] long_pulse,
    output logic [N_KEYS-1:0] repeat_pulse,
    output logic [N_KEYS-1:0] key_held
);

    for (genvar i = 0; i < N_KEYS; i++) begin : g_key
        key_event_fsm #(
            .LONG_CYCLES  (LONG_CYCLES),
            .REPEAT_CYCLES(REPEAT_CYCLES),
            .CNT_W        (CNT_W)
        ) u_fsm (
            .clk_50MHz    (clk_50MHz),
            .reset        (reset),
            .key_in       (key_in[i]),
            .press_pulse  (press_pulse[i]),
            .release_pulse(release_pulse[i]),
            .long_pulse   (long_pulse[i]),
            .repeat_pulse (repeat_pulse[i]),
            .key_held     (key_held[i])
        );
    end

endmodule

// File: tb/tb_key_event_decoder.sv
// Directed and random stimulus for key_event_decoder checked against a run-length reference model.
module tb_key_event_decoder;

    localparam int N  = 4;
    localparam int LC = 8;
    localparam int RC = 4;

    logic         clk_50MHz = 1'b0;
    logic         reset     = 1'b1;
    logic [N-1:0] key_in    = '0;
    logic [N-1:0] press_pulse, release_pulse, long_pulse, repeat_pulse, key_held;

    int tests  = 0;
    int failed = 0;

    // Model state: last sampled key level and edges held since the press edge.
    bit           prev_q [N];
    int           run    [N];
    logic [N-1:0] exp_press = '0, exp_rel = '0, exp_long = '0, exp_rep = '0, exp_held = '0;
    logic [N-1:0] long_seen = '0, rel_seen = '0;

    key_event_decoder #(
        .N_KEYS       (N),
        .LONG_CYCLES  (LC),
        .REPEAT_CYCLES(RC),
        .CNT_W        (4)
    ) dut (
        .clk_50MHz    (clk_50MHz),
        .reset        (reset),
        .key_in       (key_in),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .long_pulse   (long_pulse),
        .repeat_pulse (repeat_pulse),
        .key_held     (key_held)
    );

    always #5 clk_50MHz = ~clk_50MHz;

    task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge(input logic [N-1:0] k, input logic r);
        for (int i = 0; i < N; i++) begin
            bit h;
            if (r) begin
                prev_q[i] = 1'b0;
                run[i]    = 0;
                exp_press[i] = 1'b0; exp_rel[i] = 1'b0; exp_long[i] = 1'b0;
                exp_rep[i]   = 1'b0; exp_held[i] = 1'b0;
            end else begin
                h = prev_q[i];
                if (k[i] && h) run[i]++;
                else run[i] = 0;
                exp_press[i] = k[i] && !h;
                exp_rel[i]   = !k[i] && h;
                exp_long[i]  = k[i] && h && (run[i] == LC);
                exp_rep[i]   = k[i] && h && (run[i] > LC) && (((run[i] - LC) % RC) == 0);
                exp_held[i]  = k[i];
                prev_q[i]    = k[i];
            end
        end
    endtask

    // Drive inputs, clock one edge, then compare every output at the falling edge.
    task automatic cycle(input logic [N-1:0] k, input logic r);
        key_in = k;
        reset  = r;
        @(posedge clk_50MHz);
        model_edge(k, r);
        @(negedge clk_50MHz);
        long_seen |= long_pulse;
        rel_seen  |= release_pulse;
        check("press",   press_pulse,   exp_press);
        check("release", release_pulse, exp_rel);
        check("long",    long_pulse,    exp_long);
        check("repeat",  repeat_pulse,  exp_rep);
        check("held",    key_held,      exp_held);
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            prev_q[i] = 1'b0;
            run[i]    = 0;
        end

        cycle(4'b0000, 1'b1);
        cycle(4'b0000, 1'b1);
        check("reset_outputs", press_pulse | release_pulse | long_pulse | repeat_pulse | key_held, 4'b0000);
        cycle(4'b0000, 1'b0);

        cycle(4'b0001, 1'b0);
        check("key0_press", press_pulse, 4'b0001);
        check("key0_held", key_held, 4'b0001);
        cycle(4'b0001, 1'b0);
        check("key0_press_once", press_pulse, 4'b0000);
        cycle(4'b0000, 1'b0);
        cycle(4'b0000, 1'b0);

        for (int c = 0; c < 21; c++) cycle(4'b0010, 1'b0);
        cycle(4'b0000, 1'b0);
        check("key1_release", release_pulse, 4'b0010);
        cycle(4'b0000, 1'b0);

        long_seen = '0;
        rel_seen  = '0;
        for (int c = 0; c < LC; c++) cycle(4'b0100, 1'b0);
        cycle(4'b0000, 1'b0);
        cycle(4'b0000, 1'b0);
        check("key2_threshold_release", rel_seen, 4'b0100);
        check("key2_no_long", long_seen, 4'b0000);

        long_seen = '0;
        cycle(4'b1001, 1'b0);
        check("key03_press", press_pulse, 4'b1001);
        cycle(4'b1001, 1'b0);
        cycle(4'b1001, 1'b0);
        cycle(4'b0001, 1'b0);
        check("key3_release", release_pulse, 4'b1000);
        for (int c = 0; c < 8; c++) cycle(4'b0001, 1'b0);
        check("key0_long_only", long_seen, 4'b0001);
        cycle(4'b0000, 1'b0);
        cycle(4'b0000, 1'b0);

        for (int c = 0; c < 10; c++) cycle(4'b0010, 1'b0);
        cycle(4'b0010, 1'b1);
        check("reset_mid_hold", press_pulse | release_pulse | long_pulse | repeat_pulse | key_held, 4'b0000);
        cycle(4'b0010, 1'b0);
        check("repress_after_reset", press_pulse, 4'b0010);
        for (int c = 0; c < LC; c++) cycle(4'b0010, 1'b0);
        check("long_after_reset", long_pulse, 4'b0010);
        cycle(4'b0000, 1'b0);

        begin
            logic [N-1:0] k;
            k = '0;
            for (int c = 0; c < 3000; c++) begin
                for (int i = 0; i < N; i++)
                    if ($urandom_range(0, 11) == 0) k[i] = ~k[i];
                cycle(k, ($urandom_range(0, 299) == 0));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/key_event_decoder.md
# key_event_decoder

Consumes the clean, debounced button levels produced by the board's input debouncer and turns them into single-cycle key events for downstream control logic. It produces press, release, long-press and auto-repeat pulses, plus a held level. Each key runs its own small state machine and hold counter. It sits between the debouncer outputs and the menu/control FSMs, all in the single `clk_50MHz` domain.

## Interface
- `N_KEYS`, 4, number of independent keys
- `LONG_CYCLES`, 25_000_000, clocks from press pulse to long pulse (≥2)
- `REPEAT_CYCLES`, 5_000_000, clocks between successive repeat pulses (≥2)
- `CNT_W`, 25, hold-counter width; must hold max(LONG_CYCLES, REPEAT_CYCLES)−1

Ports:
- `clk_50MHz`  in  1  system clock, all logic on rising edge
- `reset`  in  1  synchronous, active-high reset
- `key_in`  in  N_KEYS  debounced key levels, 1 = pressed
- `press_pulse`  out  N_KEYS  one-cycle pulse per press
- `release_pulse`  out  N_KEYS  one-cycle pulse per release
- `long_pulse`  out  N_KEYS  one-cycle pulse when hold reaches LONG_CYCLES
- `repeat_pulse`  out  N_KEYS  one-cycle pulse every REPEAT_CYCLES after long
- `key_held`  out  N_KEYS  level, 1 from press pulse until release pulse

## Operation
- Per key: register `key_q` <= `key_in[i]`. Rise = `key_in & ~key_q`; fall = `~key_in & key_q`.
- FSM states: IDLE, PRESSED, LONG.
  - IDLE: on rise -> PRESSED, `press_pulse`=1, counter=0.
  - PRESSED: counter increments each cycle. Counter == LONG_CYCLES−1 and no fall -> LONG, `long_pulse`=1, counter=0.
  - LONG: counter increments. Counter == REPEAT_CYCLES−1 and no fall -> `repeat_pulse`=1, counter=0, stay in LONG.
  - PRESSED or LONG on fall -> IDLE, `release_pulse`=1, counter=0.
- `key_held` = state != IDLE (registered).
- Simultaneous fall and threshold in the same cycle: release wins; no long or repeat pulse.
- Keys are fully independent. Any combination of simultaneous events across keys is legal and each is reported in its own bit.
- Counter never exceeds its threshold−1, so no wrap. The counter is held at 0 in IDLE.

## Timing
- All outputs are registered. Reset value of every output is 0. Reset puts all FSMs in IDLE, counters at 0 and `key_q` at 0.
- `key_in` rises before edge k: `key_q` updates at edge k, and `press_pulse` is high for the cycle following edge k.
- `long_pulse` is asserted exactly LONG_CYCLES clocks after `press_pulse`.
- The first `repeat_pulse` is asserted REPEAT_CYCLES clocks after `long_pulse`. Later repeat pulses follow every REPEAT_CYCLES clocks.
- `release_pulse` has the same one-edge latency as the press.
- `key_held` rises and falls coincident with `press_pulse` and `release_pulse` respectively.
- Reset asserted mid-hold: outputs are 0 on the next cycle with no release pulse.
- Key still high when reset deasserts: `key_q` is 0, so a rise is detected and `press_pulse` fires one cycle after reset release.

## Structure
- Shared package `key_event_pkg`:
  - state typedef (IDLE, PRESSED, LONG)
  - default LONG/REPEAT constants
- Sub-module `key_event_fsm`:
  - one key: edge register, FSM, counter, four pulse outputs and the held output
  - top instantiates N_KEYS copies in a generate loop

## Test plan
Bench parameters: LONG_CYCLES=8, REPEAT_CYCLES=4.
- Reset with `key_in`=0 -> all outputs 0. Raise `key_in[0]` before edge k -> `press_pulse[0]`=1 for exactly 1 cycle after edge k, and `key_held[0]`=1.
- Hold key 1 for 20 cycles -> press at t, long at t+8, repeats at t+12, t+16 and t+20, then release pulse on fall.
- Release key 2 with the fall landing exactly on the long threshold cycle -> `release_pulse[2]`=1 and `long_pulse[2]` never asserted.
- Press keys 0 and 3 on the same edge, release key 3 after 3 cycles -> both press pulses coincide, key 3 releases with no long pulse, and key 0 is unaffected.
- Assert `reset` for 1 cycle while key 1 is in LONG with the key still high -> all outputs 0. `press_pulse[1]` fires one cycle after reset deasserts and the long pulse follows 8 cycles later.
